// File: rtl/pc_boot_ctrl_if.sv
// Boot-control signal bundle: run/restart requests in, reset/enable/start levels out.
// master = the boot controller, slave = the CPU-side consumer.
interface pc_boot_ctrl_if;
   logic       run_req;
   logic       restart;
   logic       clk_reset;
   logic       cpu_reset;
   logic       mem_reset;
   logic       enable;
   logic       start;
   logic [2:0] phase;

   modport master (
      input  run_req, restart,
      output clk_reset, cpu_reset, mem_reset, enable, start, phase
   );

   modport slave (
      output run_req, restart,
      input  clk_reset, cpu_reset, mem_reset, enable, start, phase
   );
endinterface

// File: rtl/pc_boot_ctrl.sv
// CPU boot sequencer: timed reset release (clk, cpu, mem), then start pulse on a run_req edge.
// Latency: run_req edge to start = 3 cycles (2-flop sync + output register), more with PC_BOOT_DEBOUNCE_EN.
// No backpressure; run events outside READY are dropped, restart always wins.
module pc_boot_ctrl #(
   parameter int HOLD_CYCLES     = 25,
   parameter int START_CYCLES    = 25,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic          clock,
   input  logic          reset_n,
   pc_boot_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      HOLD_ALL = 3'd0,
      EN_ON    = 3'd1,
      CLK_UP   = 3'd2,
      CPU_UP   = 3'd3,
      READY    = 3'd4,
      START    = 3'd5,
      RUN      = 3'd6
   } state_t;

   localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] START_LAST = 16'(START_CYCLES - 1);

   state_t      state;
   state_t      next_state;
   logic [15:0] cnt;
   logic        cnt_clr;
   logic        timed;
   logic        run_s1;
   logic        run_s2;
   logic        run_evt;

   logic clk_reset_q, cpu_reset_q, mem_reset_q, enable_q, start_q;
   logic clk_reset_d, cpu_reset_d, mem_reset_d, enable_d, start_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         run_s1 <= 1'b0;
         run_s2 <= 1'b0;
      end else begin
         run_s1 <= bus.run_req;
         run_s2 <= run_s1;
      end
   end

`ifdef PC_BOOT_DEBOUNCE_EN
   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [15:0] db_cnt;
   logic        run_acc;
   logic        run_acc_d;

   // New level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt    <= '0;
         run_acc   <= 1'b0;
         run_acc_d <= 1'b0;
      end else begin
         run_acc_d <= run_acc;
         if (run_s2 == run_acc) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            run_acc <= run_s2;
            db_cnt  <= '0;
         end else begin
            db_cnt <= db_cnt + 16'd1;
         end
      end
   end

   assign run_evt = run_acc & ~run_acc_d;
`else
   localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

   logic run_s3;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         run_s3 <= 1'b0;
      end else begin
         run_s3 <= run_s2;
      end
   end

   assign run_evt = run_s2 & ~run_s3;
`endif

   always_comb begin
      next_state = state;
      case (state)
         HOLD_ALL: if (cnt == HOLD_LAST)  next_state = EN_ON;
         EN_ON:    if (cnt == HOLD_LAST)  next_state = CLK_UP;
         CLK_UP:   if (cnt == HOLD_LAST)  next_state = CPU_UP;
         CPU_UP:   if (cnt == HOLD_LAST)  next_state = READY;
         READY:    if (run_evt)           next_state = START;
         START:    if (cnt == START_LAST) next_state = RUN;
         RUN:      next_state = RUN;
         default:  next_state = HOLD_ALL;
      endcase
      if (bus.restart) begin
         next_state = HOLD_ALL;
      end
   end

   // Restart inside HOLD_ALL keeps the state but must still zero the count.
   assign cnt_clr = bus.restart || (next_state != state);
   assign timed   = (state != READY) && (state != RUN);

   // Outputs are decoded from next_state so they register on the same edge as the state.
   always_comb begin
      clk_reset_d = 1'b1;
      cpu_reset_d = 1'b1;
      mem_reset_d = 1'b1;
      enable_d    = 1'b0;
      start_d     = 1'b0;
      case (next_state)
         EN_ON: begin
            enable_d = 1'b1;
         end
         CLK_UP: begin
            enable_d    = 1'b1;
            clk_reset_d = 1'b0;
         end
         CPU_UP: begin
            enable_d    = 1'b1;
            clk_reset_d = 1'b0;
            cpu_reset_d = 1'b0;
         end
         READY, RUN: begin
            enable_d    = 1'b1;
            clk_reset_d = 1'b0;
            cpu_reset_d = 1'b0;
            mem_reset_d = 1'b0;
         end
         START: begin
            enable_d    = 1'b1;
            start_d     = 1'b1;
            clk_reset_d = 1'b0;
            cpu_reset_d = 1'b0;
            mem_reset_d = 1'b0;
         end
         default: begin
            enable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= HOLD_ALL;
         cnt         <= '0;
         clk_reset_q <= 1'b1;
         cpu_reset_q <= 1'b1;
         mem_reset_q <= 1'b1;
         enable_q    <= 1'b0;
         start_q     <= 1'b0;
      end else begin
         state       <= next_state;
         clk_reset_q <= clk_reset_d;
         cpu_reset_q <= cpu_reset_d;
         mem_reset_q <= mem_reset_d;
         enable_q    <= enable_d;
         start_q     <= start_d;
         if (cnt_clr) begin
            cnt <= '0;
         end else if (timed) begin
            cnt <= cnt + 16'd1;
         end
      end
   end

   assign bus.clk_reset = clk_reset_q;
   assign bus.cpu_reset = cpu_reset_q;
   assign bus.mem_reset = mem_reset_q;
   assign bus.enable    = enable_q;
   assign bus.start     = start_q;
   assign bus.phase     = state;

endmodule

// File: tb/tb_pc_boot_ctrl.sv
// Bench for pc_boot_ctrl: directed boot/start/restart/reset steps followed by random run_req/restart traffic,
// compared every cycle against a timeline model (cycles since sequence origin, edge index of the run event).
module tb_pc_boot_ctrl;
   localparam int H = 4;
   localparam int S = 3;
   localparam int D = 16;

   logic clock = 1'b0;
   logic reset_n;
   pc_boot_ctrl_if bus ();

   pc_boot_ctrl #(
      .HOLD_CYCLES     (H),
      .START_CYCLES    (S),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Timeline model: t = edges since reset/restart, start_t = edge index at which START began (-1: none).
   int t;
   int start_t;
   bit r_p1;
   bit l1, l2;
   bit acc;
   bit s2q[$];
   int first, hi, pulses;
   bit rr, rs, prev_start;

   function automatic int exp_phase();
      if (start_t >= 0) return ((t - start_t) < S) ? 5 : 6;
      return (t < 4 * H) ? (t / H) : 4;
   endfunction

   task automatic model_reset();
      t       = 0;
      start_t = -1;
      r_p1    = 1'b0;
      l1      = 1'b0;
      l2      = 1'b0;
      acc     = 1'b0;
      s2q.delete();
      for (int i = 0; i < D + 2; i++) s2q.push_back(1'b0);
   endtask

   task automatic model_edge(input bit r_now, input bit rst);
      bit ev;
      bit s2n;
      bit ln;
      ev  = (exp_phase() == 4) && l1 && !l2;
      s2n = r_p1;
`ifdef PC_BOOT_DEBOUNCE_EN
      begin
         bit all_diff;
         all_diff = 1'b1;
         for (int i = 0; i < D; i++)
            if (s2q[s2q.size() - 1 - i] == acc) all_diff = 1'b0;
         if (all_diff) acc = !acc;
         ln = acc;
      end
`else
      ln = s2n;
`endif
      s2q.push_back(s2n);
      if (s2q.size() > D + 4) void'(s2q.pop_front());
      l2   = l1;
      l1   = ln;
      r_p1 = r_now;
      if (rst) begin
         t       = 0;
         start_t = -1;
      end else begin
         t = t + 1;
         if (ev) start_t = t;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int ph;
      ph = exp_phase();
      chk({tag, ".phase"},     16'(bus.phase),     16'(ph));
      chk({tag, ".enable"},    16'(bus.enable),    16'(ph != 0));
      chk({tag, ".clk_reset"}, 16'(bus.clk_reset), 16'(ph < 2));
      chk({tag, ".cpu_reset"}, 16'(bus.cpu_reset), 16'(ph < 3));
      chk({tag, ".mem_reset"}, 16'(bus.mem_reset), 16'(ph < 4));
      chk({tag, ".start"},     16'(bus.start),     16'(ph == 5));
   endtask

   // Called at a falling edge: drive inputs, take one rising edge, check at the next falling edge.
   task automatic cyc(input bit r, input bit rst, input string tag);
      bus.run_req = r;
      bus.restart = rst;
      @(posedge clock);
      model_edge(r, rst);
      @(negedge clock);
      bus.restart = 1'b0;
      check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 reset_n = 1'b0;
      model_reset();
      #1 check_all(tag);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n     = 1'b0;
      bus.run_req = 1'b0;
      bus.restart = 1'b0;
      model_reset();
      repeat (3) @(negedge clock);
      check_all("reset");
      reset_n = 1'b1;

      // Boot release order and edge positions.
      for (int i = 1; i <= 4 * H + 2; i++) begin
         cyc(1'b0, 1'b0, "boot");
         if (i == H - 1)     chk("en_before_edge", 16'(bus.enable), 16'd0);
         if (i == H)         chk("en_at_edge", 16'(bus.enable), 16'd1);
         if (i == 2 * H - 1) chk("clk_rst_before", 16'(bus.clk_reset), 16'd1);
         if (i == 2 * H)     chk("clk_rst_at", 16'(bus.clk_reset), 16'd0);
         if (i == 3 * H)     chk("cpu_rst_at", 16'(bus.cpu_reset), 16'd0);
         if (i == 4 * H - 1) chk("mem_rst_before", 16'(bus.mem_reset), 16'd1);
         if (i == 4 * H)     chk("mem_rst_at", 16'(bus.mem_reset), 16'd0);
      end

      // Start pulse from a run_req rising edge in READY.
      first = -1;
      hi    = 0;
      for (int i = 1; i <= 8 + 2 * D; i++) begin
         cyc(1'b1, 1'b0, "start");
         if (bus.start === 1'b1) begin
            hi++;
            if (first < 0) first = i;
         end
      end
      chk("start_width", 16'(hi), 16'(S));
`ifndef PC_BOOT_DEBOUNCE_EN
      chk("start_delay", 16'(first), 16'd3);
`endif
      chk("run_phase", 16'(bus.phase), 16'd6);

      // Toggles in RUN are ignored; restart from RUN.
      cyc(1'b0, 1'b0, "run_tog");
      cyc(1'b1, 1'b0, "run_tog");
      cyc(1'b0, 1'b0, "run_tog");
      cyc(1'b1, 1'b1, "restart_run");
      chk("restart_phase", 16'(bus.phase), 16'd0);
      chk("restart_en", 16'(bus.enable), 16'd0);

      // Toggles during CLK_UP, then held high into READY: no start without a fresh edge.
      for (int i = 0; i < 2 * H - 1; i++) cyc(1'b0, 1'b0, "pre_clkup");
      for (int i = 0; i < H; i++) cyc(1'(i % 2), 1'b0, "clkup_tog");
      for (int i = 0; i < 2 * H + 6; i++) cyc(1'b1, 1'b0, "held_high");
`ifndef PC_BOOT_DEBOUNCE_EN
      chk("no_stale_event", 16'(bus.phase), 16'd4);
      // Restart coincides with a run event in READY.
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, "low");
      cyc(1'b1, 1'b0, "evt_sync");
      cyc(1'b1, 1'b0, "evt_sync");
      cyc(1'b1, 1'b1, "restart_vs_evt");
      chk("restart_wins", 16'(bus.phase), 16'd0);
`endif

      // Async reset in the middle of the start pulse.
      for (int i = 0; i < 4 * H + D + 4; i++) cyc(1'b0, 1'b0, "to_ready");
      for (int k = 0; k < 3 * D && exp_phase() != 5; k++) cyc(1'b1, 1'b0, "to_start");
      chk("in_start", 16'(bus.start), 16'd1);
      async_reset("mid_start_reset");
      for (int i = 0; i < 4 * H + 2; i++) cyc(1'b1, 1'b0, "reboot");

`ifdef PC_BOOT_DEBOUNCE_EN
      // Short glitch rejected, long pulse accepted once.
      for (int i = 0; i < D + 4; i++) cyc(1'b0, 1'b0, "db_low");
      pulses     = 0;
      prev_start = 1'b0;
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, "db_glitch");
      for (int i = 0; i < 30; i++) begin
         cyc(1'b0, 1'b0, "db_glitch_low");
         if (bus.start === 1'b1 && !prev_start) pulses++;
         prev_start = bus.start;
      end
      chk("db_glitch_pulses", 16'(pulses), 16'd0);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b0, "db_long");
         if (bus.start === 1'b1 && !prev_start) pulses++;
         prev_start = bus.start;
      end
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b0, "db_long_low");
         if (bus.start === 1'b1 && !prev_start) pulses++;
         prev_start = bus.start;
      end
      chk("db_long_pulses", 16'(pulses), 16'd1);
`endif

      // Random run_req / restart / reset traffic.
      rr = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(23) == 0) rr = !rr;
         rs = ($urandom_range(149) == 0);
         if ($urandom_range(799) == 0) async_reset("rand_reset");
         else cyc(rr, rs, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
